// File: rtl/rrc_mac_sequencer.sv
// Time-multiplexed 33-tap RRC pulse-shaping filter: one signed multiplier and one
// accumulator step through the taps over a circular sample history.
module rrc_mac_sequencer #(
  parameter int WIDTH  = 7,
  parameter int CWIDTH = 9,
  parameter int TAPS   = 33,
  parameter int SHIFT  = 8,
  parameter int AWIDTH = WIDTH + CWIDTH + 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [CWIDTH-1:0] cfg_data,
  output logic              cfg_err,
  output logic              busy
);

  localparam int PW     = 6;
  localparam int LIM_HI = 2 ** (WIDTH - 1) - 1;
  localparam int LIM_LO = -(2 ** (WIDTH - 1));
  localparam int HDEF [33] = '{0, -1, 1, 0, -1, 2, 0, -2, 2, 0, -6, 8, 10, -28, -14, 111, 196,
                               111, -14, -28, 10, 8, -6, 0, 2, -2, 0, 2, -1, 0, 1, -1, 0};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            base_q, base_d;
  logic [PW-1:0]            k_q, k_d;
  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]         out_q, out_d;
  logic                     cfg_err_q, cfg_err_d;
  logic signed [WIDTH-1:0]  hist_q [TAPS];
  logic signed [CWIDTH-1:0] coef_q [TAPS];

  logic                     hist_we, coef_we;
  logic [PW-1:0]            rd_idx;
  logic signed [AWIDTH-1:0] prod, final_sum, shifted;

  // k=0 reads the just-written slot; older samples sit at lower addresses, modulo TAPS.
  always_comb begin
    rd_idx    = (base_q >= k_q) ? (base_q - k_q) : (base_q + PW'(TAPS) - k_q);
    prod      = AWIDTH'(coef_q[k_q]) * AWIDTH'(hist_q[rd_idx]);
    final_sum = acc_q + prod;
    shifted   = final_sum >>> SHIFT;
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    base_d    = base_q;
    k_d       = k_q;
    acc_d     = acc_q;
    out_d     = out_q;
    hist_we   = 1'b0;
    coef_we   = cfg_we && (state_q == IDLE) && (cfg_addr < PW'(TAPS));
    cfg_err_d = cfg_we && !coef_we;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hist_we  = 1'b1;
          base_d   = wr_ptr_q;
          wr_ptr_d = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + PW'(1);
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = final_sum;
        if (k_q == PW'(TAPS - 1)) begin
          if (shifted > AWIDTH'(LIM_HI))      out_d = WIDTH'(LIM_HI);
          else if (shifted < AWIDTH'(LIM_LO)) out_d = WIDTH'(LIM_LO);
          else                                out_d = shifted[WIDTH-1:0];
          state_d = OUT;
        end else begin
          k_d = k_q + PW'(1);
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= CWIDTH'(HDEF[i]);
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      out_q     <= out_d;
      cfg_err_q <= cfg_err_d;
      if (hist_we) hist_q[wr_ptr_q] <= in_data;
      if (coef_we) coef_q[cfg_addr] <= cfg_data;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_rrc_mac_sequencer.sv
// Randomized bench for rrc_mac_sequencer against a shift-register convolution model.
module tb_rrc_mac_sequencer;

  localparam int WIDTH  = 7;
  localparam int CWIDTH = 9;
  localparam int TAPS   = 33;
  localparam int HDEF [TAPS] = '{0, -1, 1, 0, -1, 2, 0, -2, 2, 0, -6, 8, 10, -28, -14, 111, 196,
                                 111, -14, -28, 10, 8, -6, 0, 2, -2, 0, 2, -1, 0, 1, -1, 0};

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_data;
  logic              cfg_we = 1'b0;
  logic [5:0]        cfg_addr = '0;
  logic [CWIDTH-1:0] cfg_data = '0;
  logic              cfg_err;
  logic              busy;

  rrc_mac_sequencer #(.WIDTH(WIDTH), .CWIDTH(CWIDTH), .TAPS(TAPS), .SHIFT(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: mh[0] is the newest sample, mh[k] the k-th older one.
  int mh [TAPS];
  int mc [TAPS];

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mh[i] = 0;
      mc[i] = HDEF[i];
    end
  endfunction

  function automatic void model_push(input int x);
    for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
  endfunction

  function automatic int model_out();
    int acc = 0;
    int t;
    for (int i = 0; i < TAPS; i++) acc += mc[i] * mh[i];
    t = acc >>> 8;
    if (t > 63) return 63;
    if (t < -64) return -64;
    return t;
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(127)) - 64;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_cyc;
  int last_out;
  int imp [TAPS];

  task automatic start_sample(input int x, input bit we, input int addr, input int data);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = WIDTH'(x);
    cfg_we   = we;
    cfg_addr = 6'(addr);
    cfg_data = CWIDTH'(data);
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    acc_cyc  = cyc;
    if (we && addr < TAPS) mc[addr] = data;
    model_push(x);
  endtask

  task automatic finish_sample(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check({tag, "_latency"}, cyc - acc_cyc, 33);
    last_out = int'($signed(out_data));
    check({tag, "_data"}, last_out, model_out());
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #2;
    model_reset();
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic run_impulse(input string tag);
    for (int i = 0; i < TAPS; i++) begin
      start_sample((i == 0) ? 63 : 0, 1'b0, 0, 0);
      finish_sample(tag);
      imp[i] = last_out;
    end
  endtask

  initial begin
    int hold;
    int prev_acc;

    model_reset();
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_busy", int'(busy), 0);
    step();
    rstn = 1'b1;
    step();

    // Impulse response
    run_impulse("imp");
    check("imp_out16", imp[16], 48);
    check("imp_out15", imp[15], 27);
    check("imp_out17", imp[17], 27);
    check("imp_out13", imp[13], -7);
    check("imp_out0", imp[0], 0);

    // Saturation both directions
    apply_reset();
    for (int i = 0; i < TAPS; i++) begin
      start_sample(63, 1'b0, 0, 0);
      finish_sample("satp");
    end
    check("sat_pos", last_out, 63);
    for (int i = 0; i < TAPS; i++) begin
      start_sample(-64, 1'b0, 0, 0);
      finish_sample("satn");
    end
    check("sat_neg", last_out, -64);

    // Coefficient write alongside the sample, then a full impulse with h16=0
    apply_reset();
    start_sample(63, 1'b1, 16, 0);
    finish_sample("cfg_imp");
    imp[0] = last_out;
    check("cfg_first_out", last_out, 0);
    for (int i = 1; i < TAPS; i++) begin
      start_sample(0, 1'b0, 0, 0);
      finish_sample("cfg_imp");
      imp[i] = last_out;
    end
    check("cfg_imp_out16", imp[16], 0);
    check("cfg_imp_out15", imp[15], 27);

    // Write during MAC is rejected
    start_sample(rand_sample(), 1'b0, 0, 0);
    repeat (5) step();
    cfg_we = 1'b1; cfg_addr = 6'd5; cfg_data = CWIDTH'(100);
    step();
    cfg_we = 1'b0;
    check("cfg_err_mac", int'(cfg_err), 1);
    step();
    check("cfg_err_mac_clear", int'(cfg_err), 0);
    finish_sample("cfg_mac");

    // Out-of-range address in IDLE
    step();
    check("idle_in_ready", int'(in_ready), 1);
    cfg_we = 1'b1; cfg_addr = 6'd40; cfg_data = CWIDTH'(77);
    step();
    cfg_we = 1'b0;
    check("cfg_err_addr", int'(cfg_err), 1);
    step();
    check("cfg_err_addr_clear", int'(cfg_err), 0);

    // Backpressure
    out_ready = 1'b0;
    start_sample(rand_sample(), 1'b0, 0, 0);
    finish_sample("bp");
    hold = last_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(rand_sample());
      step();
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'($signed(out_data)), hold);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);

    // Streaming across wr_ptr wraps
    prev_acc = 0;
    for (int i = 0; i < 70; i++) begin
      start_sample(rand_sample(), 1'b0, 0, 0);
      if (i > 0) check("stream_period", acc_cyc - prev_acc, 35);
      prev_acc = acc_cyc;
      finish_sample("stream");
    end

    // Reset in the middle of MAC
    start_sample(rand_sample(), 1'b0, 0, 0);
    repeat (10) step();
    check("midmac_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    model_reset();
    step();
    rstn = 1'b1;
    step();
    check("midrst_no_output", int'(out_valid), 0);
    run_impulse("imp2");
    check("imp2_out16", imp[16], 48);
    check("imp2_out13", imp[13], -7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
